change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Downstream stage of the vending money-handling path. Consumes the vend-complete flag and change amount produced by the money-acceptance stage. Pays the change out as physical coins by greedy selection: quarters, then dimes, then nickels. Tracks coin-tube inventory and drives the have_coins signal back upstream, which sets that stage's exact-change-only indication.

Parameters:
QUARTER_INIT, 20, quarter-tube count loaded at reset/refill (0-255)
DIME_INIT, 20, dime-tube count loaded at reset/refill (0-255)
NICKEL_INIT, 20, nickel-tube count loaded at reset/refill (0-255)
PULSE_CYCLES, 4, ejector solenoid pulse width in clocks (>=1)
GAP_CYCLES, 2, idle clocks between consecutive ejections (>=1)
LOW_THRESH, 2, minimum dime and nickel count for have_coins=1

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
done  input  1  vend-complete level from upstream; held high until upstream is disabled
change_back  input  8  change owed in cents, valid while done=1
refill  input  1  service strobe: restock all tubes to *_INIT
eject_quarter  output  1  quarter solenoid drive
eject_dime  output  1  dime solenoid drive
eject_nickel  output  1  nickel solenoid drive
busy  output  1  high from latch of a request until change_done
change_done  output  1  one-cycle pulse when payout finishes
shortfall  output  8  cents not payable from the last request, held until the next request
have_coins  output  1  registered; 1 when dime_cnt>=LOW_THRESH and nickel_cnt>=LOW_THRESH
total_dispensed  output  16  see Optional Feature

Behaviour:
- Reset (async, reset_n=0):
  - all eject_* =0, busy=0, change_done=0, shortfall=0, total_dispensed=0
  - tube counters (8-bit each) = *_INIT; have_coins reflects the reset counts from the first clock after release
  - done_q=0; FSM=IDLE
- Edge detect: done_q registers done each clock. A request is done=1 & done_q=0 seen in IDLE.
- FSM states:
  - IDLE: on request, latch rem=change_back, busy<=1, clear shortfall, go SELECT. Refill is honoured only here (counters<=*_INIT); refill and request in the same cycle: refill applies, then the request is latched.
  - SELECT (1 cycle), greedy choice:
    - rem>=25 & q_cnt>0: quarter
    - else rem>=10 & d_cnt>0: dime
    - else rem>=5 & n_cnt>0: nickel
    - else go FINISH
    - On a choice: decrement that counter, subtract the coin value from rem, go EJECT.
  - EJECT: exactly one selected eject_* high for PULSE_CYCLES clocks, then GAP.
  - GAP: all ejectors low for GAP_CYCLES clocks, then SELECT.
  - FINISH (1 cycle): shortfall<=rem; change_done=1; busy<=0; go IDLE.
- Zero request: change_back=0 gives SELECT then FINISH; change_done pulses with no ejection.
- Non-multiple-of-5 residue (<5 cents) always ends up in shortfall.
- Ejector outputs are mutually exclusive; at most one high in any cycle.
- Latency per coin = 1+PULSE_CYCLES+GAP_CYCLES clocks (7 at defaults).
- Request to change_done = 1 (latch) + coins*7 + 1 (SELECT) + 1 (FINISH) clocks.
- Rising edge of done while busy is ignored; done must fall and rise again for a new request.
- refill while busy is ignored, not queued.
- Counters never wrap below 0 (guarded by the >0 checks).
- reset_n asserted mid-EJECT: ejector drops asynchronously; the in-flight coin is counted as dispensed (counter already decremented) but the counters then reload from *_INIT anyway.

Optional Feature:
COIN_AUDIT_EN
- Defined: total_dispensed accumulates cents actually ejected, adding the coin value on entry to EJECT. It saturates at 16'hFFFF, is cleared only by reset, and is not cleared by refill.
- Undefined: no accumulator logic; total_dispensed tied to 0.

Test Plan:
- Reset release, done rises with change_back=40:
  - ejection order quarter, dime, nickel, each high 4 clocks with 2-clock gaps
  - change_done on clock 24 after request latch
  - shortfall=0; q/d/n counts 19/19/19
- QUARTER_INIT=0, change_back=50 -> five dime pulses, no quarter, shortfall=0, d_cnt=15.
- Counts forced to q=1,d=0,n=0 (INIT params), change_back=35:
  - one quarter, then change_done with shortfall=10
  - have_coins=0 throughout
- change_back=0 -> no ejector activity; change_done 3 clocks after done rises; busy high 2 clocks.
- During a 40-cent payout, toggle done and pulse refill -> both ignored; payout completes unchanged. Refill afterwards in IDLE -> counts back to 20/20/20, have_coins=1.
- reset_n low during second clock of a dime EJECT -> eject_dime low in the same cycle without waiting for a clock edge, busy=0, counters=INIT. With COIN_AUDIT_EN: total_dispensed=0 after reset; 40-cent payout then reads 40.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin payout stage: pays change_back as quarters/dimes/nickels, tracks tube inventory.
// Optional cents-ejected audit accumulator is enabled with `define COIN_AUDIT_EN.
module change_dispenser #(
    parameter int unsigned QUARTER_INIT = 20,
    parameter int unsigned DIME_INIT    = 20,
    parameter int unsigned NICKEL_INIT  = 20,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned LOW_THRESH   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        done,
    input  logic [7:0]  change_back,
    input  logic        refill,
    output logic        eject_quarter,
    output logic        eject_dime,
    output logic        eject_nickel,
    output logic        busy,
    output logic        change_done,
    output logic [7:0]  shortfall,
    output logic        have_coins,
    output logic [15:0] total_dispensed
);

    localparam int unsigned TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [7:0] Q_INIT = 8'(QUARTER_INIT);
    localparam logic [7:0] D_INIT = 8'(DIME_INIT);
    localparam logic [7:0] N_INIT = 8'(NICKEL_INIT);
    localparam logic [7:0] LOW    = 8'(LOW_THRESH);
    localparam logic [7:0] Q_VAL  = 8'd25;
    localparam logic [7:0] D_VAL  = 8'd10;
    localparam logic [7:0] N_VAL  = 8'd5;
    localparam logic       HAVE_INIT = (D_INIT >= LOW) && (N_INIT >= LOW);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;

    state_t        state, state_n;
    coin_t         coin, coin_pick, eject_coin;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    rem, coin_val;
    logic [7:0]    q_cnt, d_cnt, n_cnt;
    logic          done_q, req;

    assign req = (state == IDLE) && done && !done_q;

    // Greedy pick; the nonzero-count guards are what keep the tubes from wrapping.
    always_comb begin
        coin_pick = COIN_NONE;
        coin_val  = 8'd0;
        if (rem >= Q_VAL && q_cnt != 8'd0) begin
            coin_pick = COIN_Q;
            coin_val  = Q_VAL;
        end else if (rem >= D_VAL && d_cnt != 8'd0) begin
            coin_pick = COIN_D;
            coin_val  = D_VAL;
        end else if (rem >= N_VAL && n_cnt != 8'd0) begin
            coin_pick = COIN_N;
            coin_val  = N_VAL;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE:   if (req) state_n = SELECT;
            SELECT: begin
                if (coin_pick == COIN_NONE) begin
                    state_n = FINISH;
                end else begin
                    state_n = EJECT;
                    timer_n = TW'(PULSE_CYCLES - 1);
                end
            end
            EJECT: begin
                if (timer == '0) begin
                    state_n = GAP;
                    timer_n = TW'(GAP_CYCLES - 1);
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            GAP: begin
                if (timer == '0) state_n = SELECT;
                else             timer_n = timer - TW'(1);
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    assign eject_coin = (state == SELECT) ? coin_pick : coin;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q        <= 1'b0;
            rem           <= 8'd0;
            coin          <= COIN_NONE;
            q_cnt         <= Q_INIT;
            d_cnt         <= D_INIT;
            n_cnt         <= N_INIT;
            busy          <= 1'b0;
            change_done   <= 1'b0;
            shortfall     <= 8'd0;
            have_coins    <= HAVE_INIT;
            eject_quarter <= 1'b0;
            eject_dime    <= 1'b0;
            eject_nickel  <= 1'b0;
        end else begin
            done_q      <= done;
            have_coins  <= (d_cnt >= LOW) && (n_cnt >= LOW);
            change_done <= (state == FINISH);

            // Refill before latching so a simultaneous request pays from full tubes.
            if (state == IDLE) begin
                if (refill) begin
                    q_cnt <= Q_INIT;
                    d_cnt <= D_INIT;
                    n_cnt <= N_INIT;
                end
                if (req) begin
                    rem       <= change_back;
                    busy      <= 1'b1;
                    shortfall <= 8'd0;
                end
            end

            if (state == SELECT && coin_pick != COIN_NONE) begin
                rem  <= rem - coin_val;
                coin <= coin_pick;
                case (coin_pick)
                    COIN_Q:  q_cnt <= q_cnt - 8'd1;
                    COIN_D:  d_cnt <= d_cnt - 8'd1;
                    COIN_N:  n_cnt <= n_cnt - 8'd1;
                    default: ;
                endcase
            end

            if (state == FINISH) begin
                shortfall <= rem;
                busy      <= 1'b0;
            end

            eject_quarter <= (state_n == EJECT) && (eject_coin == COIN_Q);
            eject_dime    <= (state_n == EJECT) && (eject_coin == COIN_D);
            eject_nickel  <= (state_n == EJECT) && (eject_coin == COIN_N);
        end
    end

`ifdef COIN_AUDIT_EN
    logic [15:0] total_q;
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_q} + {9'd0, coin_val};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= 16'd0;
        end else if (state == SELECT && coin_pick != COIN_NONE) begin
            total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    assign total_dispensed = total_q;
`else
    assign total_dispensed = 16'd0;
`endif

endmodule
